// File: rtl/freq_gate_scheduler.sv
// Gate-window scheduler: opens a programmable counting window, counts edge pulses inside it
// and presents the result on a valid/ready port. Optional macro: FREQ_SCHED_OVERWRITE_EN.
module freq_gate_scheduler #(
  parameter int BITS           = 12,
  parameter int CNT_W          = 7,
  parameter int DEFAULT_PERIOD = 1200
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             edge_pulse,
  input  logic [BITS-1:0]  period,
  input  logic             period_load,
  input  logic             run,
  input  logic             oneshot,
  output logic             gate,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             dropped
);

  // Result handshake: a result transfers on every rising clk edge where count_valid and
  // count_ready are both high; count/overflow hold steady while count_valid waits for ready.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GATE    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  localparam logic [BITS-1:0]  DEF_PERIOD = BITS'(DEFAULT_PERIOD);
  localparam logic [BITS-1:0]  ONE_PERIOD = BITS'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t state_q;
  state_t state_d;

  logic [BITS-1:0]  shadow_q;
  logic [BITS-1:0]  active_q;
  logic [BITS-1:0]  clk_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             ovf_q;

  logic             handshake;
  logic             last_cycle;
  logic [CNT_W-1:0] edge_next;
  logic             ovf_next;

  logic             gate_d;
  logic             busy_d;
  logic             start_window;
  logic             result_write;
  logic             drop_d;

  assign handshake  = count_valid && count_ready;
  assign last_cycle = (state_q == S_GATE) && (clk_cnt_q == (active_q - ONE_PERIOD));

  // Saturating edge count for the current gate cycle, including a pulse on the last cycle.
  always_comb begin
    edge_next = edge_cnt_q;
    ovf_next  = ovf_q;
    if (edge_pulse) begin
      if (edge_cnt_q == CNT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        edge_next = edge_cnt_q + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run || oneshot) begin
          state_d = S_GATE;
        end
      end
      S_GATE: begin
        if (last_cycle) begin
`ifdef FREQ_SCHED_OVERWRITE_EN
          state_d = run ? S_GATE : S_PRESENT;
`else
          state_d = S_PRESENT;
`endif
        end
      end
      S_PRESENT: begin
        if (handshake) begin
          state_d = run ? S_GATE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output logic; gate/busy are registered from the next state so they track state_q.
  always_comb begin
    gate_d       = (state_d == S_GATE);
    busy_d       = (state_d != S_IDLE);
    start_window = (state_d == S_GATE) && ((state_q != S_GATE) || last_cycle);
    result_write = last_cycle;
`ifdef FREQ_SCHED_OVERWRITE_EN
    drop_d       = last_cycle && count_valid && !count_ready;
`else
    drop_d       = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate <= 1'b0;
      busy <= 1'b0;
    end else begin
      gate <= gate_d;
      busy <= busy_d;
    end
  end

  // A zero period would never reach its last cycle, so it is stored as one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= DEF_PERIOD;
    end else if (period_load) begin
      shadow_q <= (period == '0) ? ONE_PERIOD : period;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= DEF_PERIOD;
    end else if (start_window) begin
      active_q <= shadow_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_cnt_q  <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else if (start_window) begin
      clk_cnt_q  <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else if (state_q == S_GATE) begin
      clk_cnt_q  <= clk_cnt_q + ONE_PERIOD;
      edge_cnt_q <= edge_next;
      ovf_q      <= ovf_next;
    end
  end

  // A new result takes priority over a handshake landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else if (result_write) begin
      count       <= edge_next;
      overflow    <= ovf_next;
      count_valid <= 1'b1;
    end else if (handshake) begin
      count_valid <= 1'b0;
    end
  end

`ifdef FREQ_SCHED_OVERWRITE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropped <= 1'b0;
    end else begin
      dropped <= drop_d;
    end
  end
`else
  assign dropped = drop_d;
`endif

  a_gate_implies_busy: assert property (
    @(posedge clk) disable iff (!reset_n) gate |-> busy);

  a_result_held: assert property (
    @(posedge clk) disable iff (!reset_n)
    (count_valid && !count_ready && !last_cycle) |=> (count_valid && $stable({overflow, count})));

  a_period_nonzero: assert property (
    @(posedge clk) disable iff (!reset_n) (active_q != '0) && (shadow_q != '0));

endmodule

// File: tb/tb_freq_gate_scheduler.sv
// Randomized bench for freq_gate_scheduler: a driver issues windows and pushes the expected
// results computed from pulse counts; a monitor pops and compares on each result handshake.
module tb_freq_gate_scheduler;
  localparam int BITS  = 12;
  localparam int CNT_W = 7;
  localparam int DEF_P = 1200;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef FREQ_SCHED_OVERWRITE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             edge_pulse = 1'b0;
  logic [BITS-1:0]  period = '0;
  logic             period_load = 1'b0;
  logic             run = 1'b0;
  logic             oneshot = 1'b0;
  logic             count_ready = 1'b1;
  logic             gate;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             count_valid;
  logic             dropped;

  freq_gate_scheduler #(.BITS(BITS), .CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_P)) dut (
    .clk(clk), .reset_n(reset_n), .edge_pulse(edge_pulse), .period(period),
    .period_load(period_load), .run(run), .oneshot(oneshot), .gate(gate), .busy(busy),
    .count(count), .overflow(overflow), .count_valid(count_valid),
    .count_ready(count_ready), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [CNT_W:0] exp_q[$];
  int shadow_m = DEF_P;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {overflow, count} for a window that saw n counted pulses.
  function automatic logic [CNT_W:0] expect_result(input int n);
    logic [CNT_W:0] r;
    if (n > CMAX) r = {1'b1, CNT_W'(CMAX)};
    else          r = {1'b0, CNT_W'(n)};
    return r;
  endfunction

  function automatic logic pick_pulse(input int pulse_n, input int pct, input int i);
    if (pulse_n >= 0) return (i < pulse_n);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_period(input int v);
    step();
    period      = BITS'(v);
    period_load = 1'b1;
    step();
    period_load = 1'b0;
    shadow_m    = (v == 0) ? 1 : v;
  endtask

  // Single measurement; optional ready stall, stray oneshots while busy.
  task automatic oneshot_window(input int pulse_n, input int pct, input int stall, input bit poke);
    int p;
    int n;
    logic [CNT_W:0] e;
    p = shadow_m;
    n = 0;
    step();
    check("idle_before_oneshot", busy, 0);
    oneshot     = 1'b1;
    edge_pulse  = 1'($urandom_range(0, 1));
    count_ready = (stall == 0);
    for (int i = 0; i < p; i++) begin
      step();
      check("oneshot_gate_open", gate, 1);
      oneshot    = poke && ($urandom_range(0, 3) == 0);
      edge_pulse = pick_pulse(pulse_n, pct, i);
      if (edge_pulse) n++;
    end
    e = expect_result(n);
    exp_q.push_back(e);
    step();
    check("oneshot_gate_closed", gate, 0);
    check("oneshot_busy_present", busy, 1);
    check("oneshot_valid", count_valid, 1);
    oneshot    = 1'b0;
    edge_pulse = 1'($urandom_range(0, 1));
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_valid", count_valid, 1);
      check("stall_result", {overflow, count}, e);
      check("stall_gate", gate, 0);
      oneshot    = poke && (s == 0);
      edge_pulse = 1'($urandom_range(0, 1));
    end
    count_ready = 1'b1;
    oneshot     = 1'b0;
    step();
    check("oneshot_idle_after", busy, 0);
    check("oneshot_valid_dropped", count_valid, 0);
    edge_pulse = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("no_extra_window", busy, 0);
    end
  endtask

  // Continuous measurement of nwin windows; run drops inside the last one.
  task automatic run_windows(input int nwin, input int pct, input int load_w, input int load_i,
                             input int load_v);
    int p;
    int n;
    step();
    check("idle_before_run", busy, 0);
    run         = 1'b1;
    count_ready = 1'b1;
    edge_pulse  = 1'($urandom_range(0, 1));
    for (int w = 0; w < nwin; w++) begin
      p = shadow_m;
      n = 0;
      for (int i = 0; i < p; i++) begin
        step();
        check("run_gate_open", gate, 1);
        period_load = 1'b0;
        edge_pulse  = pick_pulse(-1, pct, i);
        if (edge_pulse) n++;
        if (w == load_w && i == load_i) begin
          period      = BITS'(load_v);
          period_load = 1'b1;
          shadow_m    = (load_v == 0) ? 1 : load_v;
        end
        if (w == nwin - 1) run = 1'b0;
      end
      exp_q.push_back(expect_result(n));
      if (!(OVR && w < nwin - 1)) begin
        step();
        check("run_dead_cycle", gate, 0);
        check("run_valid", count_valid, 1);
        period_load = 1'b0;
        edge_pulse  = 1'($urandom_range(0, 1));
      end
    end
    step();
    check("run_idle_after", busy, 0);
    edge_pulse = 1'b0;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_gate"}, gate, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_valid"}, count_valid, 0);
    check({tag, "_dropped"}, dropped, 0);
  endtask

  // Monitor: pops one expected result per handshake.
  always @(negedge clk) begin
    if (reset_n && count_valid && count_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected none at %0t", {overflow, count}, $time);
      end else begin
        check("result", {overflow, count}, exp_q.pop_front());
        check("no_drop_on_handshake", dropped, 0);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_reset("in_reset");
    reset_n = 1'b1;
    step();
    check_all_reset("after_reset");

    // Fixed 10-cycle windows: three pulses, then continuous runs.
    load_period(10);
    oneshot_window(3, 0, 0, 1'b0);
    run_windows(3, 30, -1, 0, 0);

    // Saturation boundaries in a 200-cycle window.
    load_period(200);
    oneshot_window(130, 0, 0, 1'b0);
    oneshot_window(127, 0, 0, 1'b0);
    oneshot_window(128, 0, 0, 1'b0);

    // Long ready stall with stray oneshots.
    load_period(10);
    oneshot_window(-1, 50, 50, 1'b1);

    // Reload mid-window, then zero period.
    load_period(10);
    run_windows(2, 40, 0, 4, 20);
    load_period(0);
    run_windows(3, 50, -1, 0, 0);

    for (int k = 0; k < 6; k++) begin
      load_period($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) begin
        run_windows($urandom_range(1, 3), $urandom_range(10, 90), -1, 0, 0);
      end else begin
        oneshot_window(-1, $urandom_range(10, 90),
                       ($urandom_range(0, 1) == 1) ? $urandom_range(2, 6) : 0, 1'b1);
      end
    end

    // Asynchronous reset in the middle of a window, then default period.
    load_period(30);
    oneshot_window(5, 0, 0, 1'b0);
    step();
    oneshot = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      oneshot    = 1'b0;
      edge_pulse = 1'b1;
    end
    check("gate_before_abort", gate, 1);
    #1 reset_n = 1'b0;
    #1;
    check_all_reset("async_abort");
    edge_pulse = 1'b0;
    step();
    step();
    reset_n  = 1'b1;
    shadow_m = DEF_P;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_after_abort", busy, 0);
    end
    oneshot_window(-1, 5, 0, 1'b0);

`ifdef FREQ_SCHED_OVERWRITE_EN
    begin
      int n1;
      int n2;
      logic [CNT_W:0] e1;
      logic [CNT_W:0] e2;
      load_period(8);
      step();
      run         = 1'b1;
      count_ready = 1'b0;
      n1 = 0;
      n2 = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        check("ovr_w1_gate", gate, 1);
        edge_pulse = pick_pulse(-1, 50, i);
        if (edge_pulse) n1++;
      end
      e1 = expect_result(n1);
      for (int i = 0; i < 8; i++) begin
        step();
        check("ovr_w2_gate", gate, 1);
        if (i == 0) begin
          check("ovr_w1_valid", count_valid, 1);
          check("ovr_w1_result", {overflow, count}, e1);
        end
        run        = 1'b0;
        edge_pulse = pick_pulse(-1, 50, i);
        if (edge_pulse) n2++;
      end
      e2 = expect_result(n2);
      step();
      edge_pulse = 1'b0;
      check("ovr_dropped", dropped, 1);
      check("ovr_w2_result", {overflow, count}, e2);
      check("ovr_gate_low", gate, 0);
      exp_q.push_back(e2);
      step();
      check("ovr_dropped_once", dropped, 0);
      count_ready = 1'b1;
      step();
      step();
      check("ovr_idle", busy, 0);
    end
`endif

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
